// File: rtl/reg_file_mem_arbiter_pkg.sv
// Shared types and helpers for the register-file arbiter: request/scoreboard records,
// address-width calculation and the round-robin pointer increment.
package reg_file_arb_pkg;

    // Records are sized for the widest supported configuration; users slice down to AW / REGISTER_WIDTH.
    localparam int AW_MAX     = 16;
    localparam int DATA_W_MAX = 64;

    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

    typedef struct packed {
        logic                  write;
        logic [AW_MAX-1:0]     addr;
        logic [DATA_W_MAX-1:0] wdata;
    } req_t;

    typedef struct packed {
        logic              valid;
        logic [AW_MAX-1:0] addr;
    } sb_entry_t;

endpackage

// File: rtl/reg_file_mem_arbiter_if.sv
// Register-file memory port: one write port and one read port with one cycle of read latency.
interface ifc_reg_file_memory #(
    parameter int REGISTER_WIDTH = 32,
    parameter int AW             = 4
);
    logic [REGISTER_WIDTH-1:0] mem_write_data;
    logic [AW-1:0]             mem_write_addr;
    logic                      mem_write_en;
    logic [AW-1:0]             mem_read_addr;
    logic [REGISTER_WIDTH-1:0] mem_read_data;

    modport master (
        output mem_write_data, mem_write_addr, mem_write_en, mem_read_addr,
        input  mem_read_data
    );

    modport slave (
        input  mem_write_data, mem_write_addr, mem_write_en, mem_read_addr,
        output mem_read_data
    );
endinterface

// File: rtl/reg_file_mem_arbiter_rr.sv
// Generic round-robin picker: searches upward from rr_ptr with wrap and grants the first eligible requester.
module rr_arbiter
    import reg_file_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    localparam int IW     = clog2_min1(NUM_REQ)
)(
    input  logic [NUM_REQ-1:0] eligible,
    input  logic [IW-1:0]      rr_ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IW-1:0]      grant_idx,
    output logic               grant_any
);
    logic [IW:0]   sum;
    logic [IW-1:0] idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        sum       = '0;
        idx       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, rr_ptr} + (IW+1)'(k);
            if (sum >= (IW+1)'(NUM_REQ)) sum = sum - (IW+1)'(NUM_REQ);
            idx = sum[IW-1:0];
            if (!grant_any && eligible[idx]) begin
                grant[idx] = 1'b1;
                grant_idx  = idx;
                grant_any  = 1'b1;
            end
        end
    end
endmodule

// File: rtl/reg_file_mem_arbiter.sv
// Shares one register file among NUM_REQ valid/ready requesters, one access per cycle, round-robin;
// a write scoreboard holds back reads to addresses whose writes are not yet visible.
module reg_file_mem_arbiter
    import reg_file_arb_pkg::*;
#(
    parameter int REGISTER_WIDTH = 32,
    parameter int NUM_REGISTERS  = 16,
    parameter int NUM_REQ        = 2,
    parameter int WRITE_LATENCY  = 1,
    localparam int AW            = clog2_min1(NUM_REGISTERS)
)(
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_REQ-1:0]                req_valid,
    output logic [NUM_REQ-1:0]                req_ready,
    input  logic [NUM_REQ-1:0]                req_write,
    input  logic [NUM_REQ*AW-1:0]             req_addr,
    input  logic [NUM_REQ*REGISTER_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]                resp_valid,
    output logic [REGISTER_WIDTH-1:0]         resp_data,
    ifc_reg_file_memory.master                mem
);
    localparam int IW   = clog2_min1(NUM_REQ);
    localparam int SB_N = WRITE_LATENCY - 1;

    logic [NUM_REQ-1:0] hazard, eligible, grant;
    logic [IW-1:0]      grant_idx, rr_ptr;
    logic               grant_any, wr_issue, rd_issue;
    req_t               sel;
    logic [AW-1:0]      rd_addr_p1;
    logic [NUM_REQ-1:0] resp_vld_p1;
    logic               unused_sel;

    // Only reads are held back by the scoreboard, so a blocked reader never stalls anyone else.
    assign eligible = rst ? '0 : (req_valid & ~(~req_write & hazard));

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .eligible  (eligible),
        .rr_ptr    (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    assign req_ready = grant;

    always_comb begin
        sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel.write = req_write[i];
                sel.addr  = AW_MAX'(req_addr[i*AW +: AW]);
                sel.wdata = DATA_W_MAX'(req_wdata[i*REGISTER_WIDTH +: REGISTER_WIDTH]);
            end
        end
    end

    assign wr_issue   = grant_any & sel.write;
    assign rd_issue   = grant_any & ~sel.write;
    assign unused_sel = ^{sel.addr, sel.wdata};

    assign mem.mem_write_en   = wr_issue;
    assign mem.mem_write_addr = sel.addr[AW-1:0];
    assign mem.mem_write_data = sel.wdata[REGISTER_WIDTH-1:0];
    // Hold the last read address while idle so mem_read_data stays stable.
    assign mem.mem_read_addr  = rd_issue ? sel.addr[AW-1:0] : rd_addr_p1;

    // ---- stage p0 -> p1: pointer, held read address, pending response ----
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr      <= '0;
            rd_addr_p1  <= '0;
            resp_vld_p1 <= '0;
        end else begin
            if (grant_any) rr_ptr <= IW'(rr_next(int'(grant_idx), NUM_REQ));
            if (rd_issue) rd_addr_p1 <= sel.addr[AW-1:0];
            resp_vld_p1 <= rd_issue ? grant : '0;
        end
    end

    // Masking with rst drops a response whose read was granted just before reset.
    assign resp_valid = rst ? '0 : resp_vld_p1;
    assign resp_data  = mem.mem_read_data;

    if (WRITE_LATENCY > 1) begin : g_sb
        sb_entry_t sb_p [SB_N];

        // ---- scoreboard shift: an entry lives WRITE_LATENCY-1 cycles after its write ----
        always_ff @(posedge clk) begin
            if (rst) begin
                for (int j = 0; j < SB_N; j++) sb_p[j] <= '0;
            end else begin
                sb_p[0].valid <= wr_issue;
                sb_p[0].addr  <= sel.addr;
                for (int j = 1; j < SB_N; j++) sb_p[j] <= sb_p[j-1];
            end
        end

        always_comb begin
            hazard = '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                for (int j = 0; j < SB_N; j++) begin
                    if (sb_p[j].valid && (sb_p[j].addr == AW_MAX'(req_addr[i*AW +: AW])))
                        hazard[i] = 1'b1;
                end
            end
        end
    end else begin : g_no_sb
        assign hazard = '0;
    end
endmodule

// File: tb/tb_reg_file_mem_arbiter.sv
// Directed bench: one arbiter with WRITE_LATENCY=1 and one with WRITE_LATENCY=3, each on its own memory model.
module tb_reg_file_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid, req_write;
    logic [7:0]  req_addr;
    logic [63:0] req_wdata;
    logic [1:0]  ready1, ready3, rv1, rv3;
    logic [31:0] rd1, rd3;
    int          checks = 0;
    int          errors = 0;
    int          pulses;

    always #5 clk = ~clk;

    ifc_reg_file_memory #(.REGISTER_WIDTH(32), .AW(4)) mif1 ();
    ifc_reg_file_memory #(.REGISTER_WIDTH(32), .AW(4)) mif3 ();

    reg_file_mem_arbiter #(.REGISTER_WIDTH(32), .NUM_REGISTERS(16), .NUM_REQ(2), .WRITE_LATENCY(1)) u_dut1 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(ready1), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(rv1), .resp_data(rd1), .mem(mif1));

    reg_file_mem_arbiter #(.REGISTER_WIDTH(32), .NUM_REGISTERS(16), .NUM_REQ(2), .WRITE_LATENCY(3)) u_dut3 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(ready3), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(rv3), .resp_data(rd3), .mem(mif3));

    // Memory models: 1-cycle read latency; the second delays write visibility by two extra cycles.
    logic [31:0] mem1 [16];
    logic [31:0] mem3 [16];
    logic        w3_en_p0, w3_en_p1;
    logic [3:0]  w3_a_p0, w3_a_p1;
    logic [31:0] w3_d_p0, w3_d_p1;

    always @(posedge clk) begin
        mif1.mem_read_data <= mem1[mif1.mem_read_addr];
        mif3.mem_read_data <= mem3[mif3.mem_read_addr];
        if (rst) begin
            for (int k = 0; k < 16; k++) begin
                mem1[k] <= 32'h1000_0000 + 32'(k);
                mem3[k] <= 32'h1000_0000 + 32'(k);
            end
            w3_en_p0 <= 1'b0;
            w3_en_p1 <= 1'b0;
        end else begin
            if (mif1.mem_write_en) mem1[mif1.mem_write_addr] <= mif1.mem_write_data;
            w3_en_p0 <= mif3.mem_write_en;
            w3_a_p0  <= mif3.mem_write_addr;
            w3_d_p0  <= mif3.mem_write_data;
            w3_en_p1 <= w3_en_p0;
            w3_a_p1  <= w3_a_p0;
            w3_d_p1  <= w3_d_p0;
            if (w3_en_p1) mem3[w3_a_p1] <= w3_d_p1;
        end
    end

    task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic r, input logic [1:0] v, input logic [1:0] w,
                       input logic [3:0] a0, input logic [3:0] a1,
                       input logic [31:0] d0, input logic [31:0] d1);
        @(negedge clk);
        rst       = r;
        req_valid = v;
        req_write = w;
        req_addr  = {a1, a0};
        req_wdata = {d1, d0};
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, 2'b00, 2'b00, 4'd0, 4'd0, 32'h0, 32'h0);
    endtask

    task automatic do_reset();
        cyc(1'b1, 2'b00, 2'b00, 4'd0, 4'd0, 32'h0, 32'h0);
        cyc(1'b1, 2'b00, 2'b00, 4'd0, 4'd0, 32'h0, 32'h0);
    endtask

    initial begin
        rst = 1'b1; req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
        @(posedge clk);
        @(posedge clk);

        // Reset held with all requesters valid
        for (int c = 0; c < 3; c++) begin
            cyc(1'b1, 2'b11, 2'b01, 4'd3, 4'd4, 32'h1111, 32'h2222);
            chk_eq("rst_ready1", ready1, 2'b00);
            chk_eq("rst_ready3", ready3, 2'b00);
            chk_eq("rst_we1", mif1.mem_write_en, 1'b0);
            chk_eq("rst_we3", mif3.mem_write_en, 1'b0);
            chk_eq("rst_rv1", rv1, 2'b00);
            chk_eq("rst_rv3", rv3, 2'b00);
            chk_eq("rst_raddr1", mif1.mem_read_addr, 4'd0);
            chk_eq("rst_raddr3", mif3.mem_read_addr, 4'd0);
        end

        // Single write then read-back
        do_reset();
        cyc(1'b0, 2'b01, 2'b01, 4'd3, 4'd0, 32'hDEAD_BEEF, 32'h0);
        chk_eq("wr_ready", ready1, 2'b01);
        chk_eq("wr_en", mif1.mem_write_en, 1'b1);
        chk_eq("wr_addr", mif1.mem_write_addr, 4'd3);
        chk_eq("wr_data", mif1.mem_write_data, 32'hDEAD_BEEF);
        cyc(1'b0, 2'b01, 2'b00, 4'd3, 4'd0, 32'h0, 32'h0);
        chk_eq("rd_ready", ready1, 2'b01);
        chk_eq("rd_raddr", mif1.mem_read_addr, 4'd3);
        chk_eq("rd_we", mif1.mem_write_en, 1'b0);
        chk_eq("rd_rv_early", rv1, 2'b00);
        idle();
        chk_eq("rd_rv", rv1, 2'b01);
        chk_eq("rd_data", rd1, 32'hDEAD_BEEF);

        // Contention: grants alternate every cycle
        do_reset();
        for (int c = 0; c < 4; c++) begin
            cyc(1'b0, 2'b11, 2'b00, 4'd1, 4'd2, 32'h0, 32'h0);
            chk_eq("rr_grant", ready1, (c % 2 == 1) ? 2'b10 : 2'b01);
            chk_eq("rr_raddr", mif1.mem_read_addr, (c % 2 == 1) ? 4'd2 : 4'd1);
            if (c > 0) begin
                chk_eq("rr_rv", rv1, (c % 2 == 1) ? 2'b01 : 2'b10);
                chk_eq("rr_data", rd1, (c % 2 == 1) ? 32'h1000_0001 : 32'h1000_0002);
            end
        end
        idle();
        chk_eq("rr_rv_last", rv1, 2'b10);
        chk_eq("rr_data_last", rd1, 32'h1000_0002);

        // Read-after-write hazard with WRITE_LATENCY=3
        do_reset();
        cyc(1'b0, 2'b01, 2'b01, 4'd5, 4'd0, 32'hA5A5_0005, 32'h0);
        chk_eq("hz_wr_ready", ready3, 2'b01);
        chk_eq("hz_wr_en", mif3.mem_write_en, 1'b1);
        cyc(1'b0, 2'b11, 2'b00, 4'd6, 4'd5, 32'h0, 32'h0);
        chk_eq("hz_t1_ready", ready3, 2'b01);
        chk_eq("hz_t1_raddr", mif3.mem_read_addr, 4'd6);
        chk_eq("hz_wl1_noblock", ready1, 2'b10);
        cyc(1'b0, 2'b10, 2'b00, 4'd6, 4'd5, 32'h0, 32'h0);
        chk_eq("hz_t2_ready", ready3, 2'b00);
        chk_eq("hz_t2_rv", rv3, 2'b01);
        chk_eq("hz_t2_data", rd3, 32'h1000_0006);
        chk_eq("hz_t2_raddr", mif3.mem_read_addr, 4'd6);
        cyc(1'b0, 2'b10, 2'b00, 4'd6, 4'd5, 32'h0, 32'h0);
        chk_eq("hz_t3_ready", ready3, 2'b10);
        chk_eq("hz_t3_raddr", mif3.mem_read_addr, 4'd5);
        chk_eq("hz_t3_rv", rv3, 2'b00);
        idle();
        chk_eq("hz_t4_rv", rv3, 2'b10);
        chk_eq("hz_t4_data", rd3, 32'hA5A5_0005);

        // Reset while a read response is pending
        do_reset();
        cyc(1'b0, 2'b01, 2'b00, 4'd4, 4'd0, 32'h0, 32'h0);
        chk_eq("mr_ready", ready1, 2'b01);
        cyc(1'b1, 2'b00, 2'b00, 4'd0, 4'd0, 32'h0, 32'h0);
        chk_eq("mr_rv_a", rv1, 2'b00);
        cyc(1'b1, 2'b00, 2'b00, 4'd0, 4'd0, 32'h0, 32'h0);
        chk_eq("mr_rv_b", rv1, 2'b00);
        cyc(1'b0, 2'b11, 2'b00, 4'd1, 4'd2, 32'h0, 32'h0);
        chk_eq("mr_rv_c", rv1, 2'b00);
        chk_eq("mr_ptr0", ready1, 2'b01);
        idle();
        chk_eq("mr_rv_d", rv1, 2'b01);
        chk_eq("mr_data", rd1, 32'h1000_0001);

        // Idle hold of the read address
        do_reset();
        cyc(1'b0, 2'b01, 2'b00, 4'd7, 4'd0, 32'h0, 32'h0);
        chk_eq("ih_ready", ready1, 2'b01);
        chk_eq("ih_raddr0", mif1.mem_read_addr, 4'd7);
        pulses = 0;
        for (int c = 0; c < 4; c++) begin
            idle();
            chk_eq("ih_raddr", mif1.mem_read_addr, 4'd7);
            chk_eq("ih_data", rd1, 32'h1000_0007);
            if (rv1 != 2'b00) pulses++;
        end
        chk_eq("ih_pulses", pulses, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
